// File: rtl/spram_arbiter.sv
// spram_arbiter: two-requester arbiter/sequencer for a single-port RAM.
// Owner A or B streams one beat per cycle into registered RAM address,
// data and write-enable outputs. Read data returns through a tag pipe so
// each rvalid lands on the requester that issued the read.
// Optional feature: define SPRAM_ARB_PRIO_EN for fixed A priority
// (A wins ties, preempts B, is never burst-limited). Default is round-robin
// with a MAX_BURST fairness limit.
module spram_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req_i,
  input  logic          b_req_i,
  input  logic          a_we_i,
  input  logic          b_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic          a_gnt_o,
  output logic          b_gnt_o,
  output logic          a_rvalid_o,
  output logic          b_rvalid_o,
  output logic [DW-1:0] a_rdata_o,
  output logic [DW-1:0] b_rdata_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  output logic          ram_we_o,
  input  logic [DW-1:0] ram_dout_i,
  output logic          busy_o
);

`ifdef SPRAM_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e        state_q, state_d;
  logic          last_b_q, last_b_d;      // 1: B was served most recently
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic [RD_LAT:0] vld_pipe_q;            // read tag valid, stage RD_LAT is output
  logic [RD_LAT:0] own_pipe_q;            // read tag owner, 1 = B
  logic          a_beat, b_beat;
  logic          rd_push, rd_own_b;
  logic          at_limit;

  assign a_gnt_o  = (state_q == OWN_A);
  assign b_gnt_o  = (state_q == OWN_B);
  assign a_beat   = a_gnt_o && a_req_i;
  assign b_beat   = b_gnt_o && b_req_i;
  assign at_limit = (burst_cnt_q == BURST_LAST);

  // Next owner, fairness pointer and burst counter.
  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (a_req_i && b_req_i) state_d = (PRIO_EN || last_b_q) ? OWN_A : OWN_B;
        else if (a_req_i)       state_d = OWN_A;
        else if (b_req_i)       state_d = OWN_B;
      end
      OWN_A: begin
        if (!a_req_i) begin
          last_b_d = 1'b0;
          state_d  = b_req_i ? OWN_B : IDLE;
        end else if (PRIO_EN) begin
          // A is never preempted; the count is irrelevant here
          burst_cnt_d = '0;
        end else if (at_limit) begin
          burst_cnt_d = '0;
          if (b_req_i) begin
            last_b_d = 1'b0;
            state_d  = OWN_B;
          end
        end else begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end
      OWN_B: begin
        if (!b_req_i) begin
          last_b_d = 1'b1;
          state_d  = a_req_i ? OWN_A : IDLE;
        end else if (PRIO_EN && a_req_i) begin
          // B's beat this cycle still completes; A takes over next edge
          last_b_d = 1'b1;
          state_d  = OWN_A;
        end else if (at_limit) begin
          burst_cnt_d = '0;
          if (a_req_i) begin
            last_b_d = 1'b1;
            state_d  = OWN_A;
          end
        end else begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) burst_cnt_d = '0;
  end

  // Load the accepted beat into the RAM port registers; idle cycles drop we.
  always_comb begin
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rd_push    = 1'b0;
    rd_own_b   = 1'b0;
    if (a_beat) begin
      ram_we_d   = a_we_i;
      ram_addr_d = a_addr_i;
      ram_din_d  = a_wdata_i;
      rd_push    = !a_we_i;
    end else if (b_beat) begin
      ram_we_d   = b_we_i;
      ram_addr_d = b_addr_i;
      ram_din_d  = b_wdata_i;
      rd_push    = !b_we_i;
      rd_own_b   = 1'b1;
    end
  end

  // Control and RAM port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      burst_cnt_q <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      burst_cnt_q <= burst_cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
    end
  end

  // Read tag pipe: 1 stage for the address register plus RD_LAT for the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      own_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], rd_push};
      own_pipe_q <= {own_pipe_q[RD_LAT-1:0], rd_own_b};
    end
  end

  assign a_rvalid_o = vld_pipe_q[RD_LAT] && !own_pipe_q[RD_LAT];
  assign b_rvalid_o = vld_pipe_q[RD_LAT] &&  own_pipe_q[RD_LAT];
  assign a_rdata_o  = ram_dout_i;
  assign b_rdata_o  = ram_dout_i;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign ram_we_o   = ram_we_q;
  assign busy_o     = (state_q != IDLE) || (|vld_pipe_q);

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: behavioural RAM, transaction-level reference
// model with per-cycle compare, and phase-specific literal expectations.
module tb_spram_arbiter;
  localparam int AW = 10, DW = 16, RD_LAT = 1, MAX_BURST = 16;
`ifdef SPRAM_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam int PH_IDLE = 0, PH_W = 1, PH_T1 = 2, PH_T2 = 3, PH_IL = 4,
                 PH_ST = 5, PH_R = 6, PH_RAND = 7;

  logic clk = 1'b0, rst = 1'b1;
  logic a_req = 0, b_req = 0, a_we = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, busy;
  logic [DW-1:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  int nvec = 0, nerr = 0, cyc = 0, phase = PH_IDLE;
  bit tmo = 0, tmo_rep = 0;

  always #5 clk = ~clk;

  spram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .b_req_i(b_req), .a_we_i(a_we), .b_we_i(b_we),
    .a_addr_i(a_addr), .b_addr_i(b_addr), .a_wdata_i(a_wdata), .b_wdata_i(b_wdata),
    .a_gnt_o(a_gnt), .b_gnt_o(b_gnt), .a_rvalid_o(a_rvalid), .b_rvalid_o(b_rvalid),
    .a_rdata_o(a_rdata), .b_rdata_o(b_rdata),
    .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_we_o(ram_we),
    .ram_dout_i(ram_dout), .busy_o(busy));

  // Behavioural single-port RAM with RD_LAT read latency.
  logic [DW-1:0] ram_mem [0:1023];
  logic [DW-1:0] rd_pipe [0:1];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    rd_pipe[0] <= ram_mem[ram_addr];
    rd_pipe[1] <= rd_pipe[0];
  end
  assign ram_dout = rd_pipe[RD_LAT-1];

  // Reference model: owner (0 none, 1 A, 2 B), last served, beats in burst,
  // registered port image, memory image and expected read returns.
  typedef struct { int due; bit b; bit known; int data; } rd_t;
  rd_t rq[$];
  int  m_own = 0, m_last = 2, m_cnt = 0, m_addr = 0, m_din = 0;
  bit  m_we = 0;
  int  mdl_mem [0:1023];
  bit  mdl_known [0:1023];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  // Phase bookkeeping for literal expectations.
  int ph_prev = -1, req_c = -1, k = 0, run = 0, prev_o = 0;
  bit first_g = 0, seen = 0;
  bit ea, eb, ek, bt_a, bt_b, xr, orq, we;
  int ed, ad, wd, oth, cur;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_own = 0; m_last = 2; m_cnt = 0; m_we = 0; m_addr = 0; m_din = 0;
      rq.delete();
    end
    ea = 0; eb = 0; ek = 0; ed = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ea = !rq[0].b; eb = rq[0].b; ek = rq[0].known; ed = rq[0].data;
    end
    chk("a_gnt", 32'(a_gnt), 32'(m_own == 1));
    chk("b_gnt", 32'(b_gnt), 32'(m_own == 2));
    chk("ram_we", 32'(ram_we), 32'(m_we));
    chk("ram_addr", 32'(ram_addr), m_addr);
    chk("ram_din", 32'(ram_din), m_din);
    chk("a_rvalid", 32'(a_rvalid), 32'(ea));
    chk("b_rvalid", 32'(b_rvalid), 32'(eb));
    chk("busy", 32'(busy), 32'(m_own != 0 || rq.size() > 0));
    if (ea && ek) chk("a_rdata", 32'(a_rdata), ed);
    if (eb && ek) chk("b_rdata", 32'(b_rdata), ed);
    if (tmo && !tmo_rep) begin
      tmo_rep = 1; nvec++; nerr++;
      $display("FAIL timeout got=no_grant exp=grant cyc=%0d", cyc);
    end

    if (phase != ph_prev) begin
      ph_prev = phase; first_g = 0; req_c = -1; k = 0; run = 0; prev_o = 0; seen = 0;
    end
    case (phase)
      PH_W: begin
        if (req_c < 0 && a_req) req_c = cyc;
        if (!first_g && a_gnt) begin first_g = 1; chk("gnt_latency", cyc - req_c, 1); end
        if (a_rvalid) begin chk("w_rdata_lit", 32'(a_rdata), 32'h1000 + k); k++; end
      end
      PH_T1: if (!first_g && (a_gnt || b_gnt)) begin first_g = 1; chk("tie1_a_first", 32'(a_gnt), 1); end
      PH_T2: if (!first_g && (a_gnt || b_gnt)) begin first_g = 1; chk("tie2_b_first", 32'(b_gnt), 1); end
      PH_IL: begin
        if (a_rvalid) begin req_c = cyc; chk("il_a_lit", 32'(a_rdata), 32'h0555); end
        if (b_rvalid) begin
          chk("il_b_lit", 32'(b_rdata), 32'h0999);
          chk("il_a_before_b", 32'(req_c >= 0), 1);
        end
      end
      PH_ST: begin
        if (a_gnt || b_gnt) begin
          cur = a_gnt ? 1 : 2;
          if (prev_o != 0 && cur != prev_o) begin chk("burst_len", run, MAX_BURST); run = 0; end
          prev_o = cur; run++; seen = 1;
        end else if (seen) chk("stream_gap", 0, 1);
      end
      PH_R: begin
        if (rst) seen = 1;
        else if (seen) chk("rst_no_rvalid", 32'(a_rvalid | b_rvalid), 0);
      end
      default: ;
    endcase

    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());

    if (!rst) begin
      if (m_we) begin mdl_mem[m_addr] = m_din; mdl_known[m_addr] = 1; end
      bt_a = (m_own == 1) && a_req;
      bt_b = (m_own == 2) && b_req;
      m_we = 0;
      if (bt_a || bt_b) begin
        we = bt_a ? a_we : b_we;
        ad = bt_a ? int'(a_addr) : int'(b_addr);
        wd = bt_a ? int'(a_wdata) : int'(b_wdata);
        m_we = we; m_addr = ad; m_din = wd;
        if (!we) rq.push_back('{due: cyc + 1 + RD_LAT, b: bt_b, known: mdl_known[ad], data: mdl_mem[ad]});
      end
      if (m_own == 0) begin
        if (a_req && b_req) m_own = (PRIO || m_last == 2) ? 1 : 2;
        else if (a_req) m_own = 1;
        else if (b_req) m_own = 2;
        m_cnt = 0;
      end else begin
        xr  = (m_own == 1) ? a_req : b_req;
        orq = (m_own == 1) ? b_req : a_req;
        oth = 3 - m_own;
        if (!xr) begin m_last = m_own; m_own = orq ? oth : 0; m_cnt = 0; end
        else if (PRIO && m_own == 2 && a_req) begin m_last = 2; m_own = 1; m_cnt = 0; end
        else if (PRIO && m_own == 1) m_cnt = 0;
        else if (m_cnt == MAX_BURST - 1) begin
          m_cnt = 0;
          if (orq) begin m_last = m_own; m_own = oth; end
        end else m_cnt++;
      end
    end
  end

  // Stimulus helpers: all start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input bit sel_b, input bit w, input int addr, input int data);
    int n = 0;
    if (sel_b) begin b_req = 1; b_we = w; b_addr = AW'(addr); b_wdata = DW'(data); end
    else       begin a_req = 1; a_we = w; a_addr = AW'(addr); a_wdata = DW'(data); end
    do begin @(negedge clk); n++; end while (!(sel_b ? b_gnt : a_gnt) && n < 40);
    if (!(sel_b ? b_gnt : a_gnt)) tmo = 1;
    @(posedge clk); #1;
  endtask

  task automatic both_once(input bit aw, input int aad, input int adat,
                           input bit bw, input int bad, input int bdat);
    bit ga, gb, ad_done = 0, bd_done = 0;
    int n = 0;
    a_req = 1; a_we = aw; a_addr = AW'(aad); a_wdata = DW'(adat);
    b_req = 1; b_we = bw; b_addr = AW'(bad); b_wdata = DW'(bdat);
    while (!(ad_done && bd_done) && n < 40) begin
      @(negedge clk); n++;
      ga = a_gnt && a_req; gb = b_gnt && b_req;
      @(posedge clk); #1;
      if (ga) begin a_req = 0; ad_done = 1; end
      if (gb) begin b_req = 0; bd_done = 1; end
    end
    if (!(ad_done && bd_done)) tmo = 1;
    a_req = 0; b_req = 0;
  endtask

  task automatic rand_cycles(input int n, input bit force_req);
    bit ha, hb;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ha = a_req && !a_gnt; hb = b_req && !b_gnt;
      @(posedge clk); #1;
      if (!ha) begin
        a_req = force_req || ($urandom % 4 != 0); a_we = 1'($urandom % 2);
        a_addr = AW'(($urandom % 8 == 0) ? $urandom % 1024 : $urandom % 16);
        a_wdata = DW'($urandom);
      end
      if (!hb) begin
        b_req = force_req || ($urandom % 4 != 0); b_we = 1'($urandom % 2);
        b_addr = AW'(($urandom % 8 == 0) ? $urandom % 1024 : $urandom % 16);
        b_wdata = DW'($urandom);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1; idle(n); rst = 0;
  endtask

  initial begin
    idle(3); rst = 0;
    idle(2);
    phase = PH_W;
    for (int i = 0; i < 4; i++) beat(0, 1, i, 32'h1000 + i);
    for (int i = 0; i < 4; i++) beat(0, 0, i, 0);
    a_req = 0; idle(6);

    do_reset(2);
    phase = PH_T1;
    both_once(1, 7, 32'h77, 1, 8, 32'h88);
    idle(3);
    phase = PH_IDLE;
    beat(0, 0, 7, 0); a_req = 0; idle(3);
    phase = PH_T2;
    both_once(0, 8, 0, 0, 7, 0);
    idle(4);

    phase = PH_IDLE;
    beat(1, 1, 5, 32'h0555); beat(1, 1, 9, 32'h0999); b_req = 0; idle(3);
    phase = PH_IL;
    both_once(0, 5, 0, 0, 9, 0);
    idle(6);

    phase = PH_ST;
    rand_cycles(100, 1);
    phase = PH_IDLE; a_req = 0; b_req = 0; idle(5);

    phase = PH_R;
    beat(0, 1, 20, 32'hABCD);
    for (int i = 0; i < 5; i++) beat(0, 0, i, 0);
    rst = 1; idle(3); rst = 0; a_req = 0; idle(6);

    phase = PH_RAND;
    rand_cycles(1500, 0);
    phase = PH_IDLE; a_req = 0; b_req = 0; idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
